// File: rtl/vga_pkg.sv
// vga_pkg: shared frame-buffer geometry, display timing limits and scheduler state encoding
package vga_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int ADDR_W = 17;
  localparam int HACTIVE = 640;
  localparam int VACTIVE = 480;
  typedef enum logic [1:0] {IDLE, WAIT_VBLANK, WRITING} state_t;
endpackage

// File: rtl/raster_addr_counter.sv
// raster_addr_counter: frame write address counter with clear, increment and terminal flag
module raster_addr_counter #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int LAST = vga_pkg::FB_PIXELS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : cnt_q + ADDR_W'(inc);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign last = cnt_q == ADDR_W'(LAST);
endmodule

// File: rtl/frame_port_scheduler.sv
// frame_port_scheduler: shares one RAM port between 2x-upscaled display reads and frame capture writes
module frame_port_scheduler #(
  parameter int FB_W = vga_pkg::FB_W,
  parameter int FB_H = vga_pkg::FB_H,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              vgaClk,
  input  logic              rst,
  input  logic [9:0]        hCount,
  input  logic [8:0]        vCount,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        pixel,
  output logic              busy,
  output logic              done
);
  import vga_pkg::*;
  state_t state_q, state_d;
  logic slot_q, slot_d, active_q, active_d, done_q, done_d;
  logic [7:0] pixel_q, pixel_d;
  logic active, disp_slot, vb_hit, accept, clr, wr_last;
  logic [ADDR_W-1:0] wr_addr, disp_addr;
  assign active = hCount < 10'(HACTIVE) && vCount < 9'(VACTIVE);
  // even columns of the active region always own the RAM port
  assign disp_slot = active && !hCount[0];
  assign vb_hit = hCount == '0 && vCount == 9'(VACTIVE);
  assign disp_addr = ADDR_W'(32'(vCount[8:1]) * FB_W + 32'(hCount[9:1]));
  assign clr = state_q == WAIT_VBLANK && vb_hit;
  raster_addr_counter #(.ADDR_W(ADDR_W), .LAST(FB_W * FB_H - 1)) u_cnt (
    .clk(vgaClk), .rst(rst), .clr(clr), .inc(accept), .cnt(wr_addr), .last(wr_last)
  );
  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE && start ? WAIT_VBLANK :
              state_q == WAIT_VBLANK && vb_hit ? WRITING :
              state_q == WRITING && accept && wr_last ? IDLE : state_q;
  end
  always_comb begin
    wr_ready = state_q == WRITING && !disp_slot;
    accept = wr_ready && wr_valid;
    ram_we = accept;
    ram_addr = disp_slot ? disp_addr : wr_addr;
    ram_wdata = wr_data;
    busy = state_q != IDLE;
    done = done_q;
    pixel = pixel_q;
  end
  // read data lands one cycle after the slot; the odd column repeats it, blanking forces 0
  always_comb begin
    slot_d = disp_slot;
    active_d = active;
    done_d = accept && wr_last;
    pixel_d = slot_q ? ram_rdata : active_q ? pixel_q : 8'h00;
  end
  always_ff @(posedge vgaClk or posedge rst) begin
    if (rst) begin
      slot_q <= 1'b0;
      active_q <= 1'b0;
      done_q <= 1'b0;
      pixel_q <= 8'h00;
    end else begin
      slot_q <= slot_d;
      active_q <= active_d;
      done_q <= done_d;
      pixel_q <= pixel_d;
    end
  end
endmodule

// File: tb/tb_frame_port_scheduler.sv
// tb_frame_port_scheduler: directed self-checking bench with a 1-cycle-latency RAM model
module tb_frame_port_scheduler;
  localparam int NPIX = 76800;
  logic vgaClk = 1'b0, rst = 1'b0, start = 1'b0, wr_valid = 1'b0;
  logic wr_ready, ram_we, busy, done;
  logic [9:0] hCount = '0;
  logic [8:0] vCount = '0;
  logic [7:0] wr_data = '0, ram_rdata = '0, ram_wdata, pixel;
  logic [16:0] ram_addr;
  logic [7:0] mem [0:131071];
  logic fill = 1'b1, fill_a5 = 1'b0;
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_we = 0, n_done = 0;
  int bad_addr = 0, bad_data = 0, we_in_slot = 0, ready_bad = 0, done_bad = 0;
  int gh = 0, gv = 0;
  bit took = 1'b0, exp_wr = 1'b0;

  always #5 vgaClk = ~vgaClk;

  frame_port_scheduler dut (
    .vgaClk(vgaClk), .rst(rst), .hCount(hCount), .vCount(vCount), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pixel(pixel),
    .busy(busy), .done(done)
  );

  always @(posedge vgaClk) begin
    if (fill) begin
      for (int a = 0; a < 131072; a++) mem[a] <= fill_a5 ? 8'hA5 : a[7:0];
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit slot(input int h, input int v);
    return h < 640 && v < 480 && h % 2 == 0;
  endfunction

  task automatic cyc(input int h, input int v);
    bit fin, rdy;
    @(posedge vgaClk);
    fin = took && n_acc == NPIX - 1;
    if (took) n_acc++;
    if (n_acc == NPIX) exp_wr = 1'b0;
    #1;
    hCount = 10'(h);
    vCount = 9'(v);
    wr_data = n_acc[7:0];
    #1;
    gh = h;
    gv = v;
    took = wr_valid && wr_ready;
    rdy = exp_wr && !slot(h, v);
    if (wr_ready !== rdy || ram_we !== (rdy && wr_valid)) ready_bad++;
    if (ram_we === 1'b1) begin
      n_we++;
      if (ram_addr !== n_acc[16:0]) bad_addr++;
      if (ram_wdata !== n_acc[7:0]) bad_data++;
      if (slot(h, v)) we_in_slot++;
    end
    if (done === 1'b1) n_done++;
    if (done !== fin) done_bad++;
  endtask

  task automatic step();
    int h, v;
    h = gh + 1;
    v = gv;
    if (h == 800) begin
      h = 0;
      v = (gv + 1) % 500;
    end
    cyc(h, v);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_pixel", pixel, 0);
    cyc(0, 0);
    fill = 1'b0;
    cyc(0, 0);
    rst = 1'b0;
    for (int h = 0; h <= 645; h++) begin
      cyc(h, 3);
      if (h == 10) begin
        chk("slot_addr", ram_addr, 325);
        chk("slot_we", ram_we, 0);
      end
      if (h == 12) chk("pix_h12", pixel, 'h45);
      if (h == 13) chk("pix_h13", pixel, 'h45);
      if (h == 14) chk("pix_h14", pixel, 'h46);
      if (h == 641) chk("pix_last", pixel, 'h7f);
      if (h == 642) chk("pix_blank", pixel, 0);
    end
    wr_valid = 1'b1;
    cyc(0, 100);
    start = 1'b1;
    cyc(1, 100);
    start = 1'b0;
    chk("busy_wait", busy, 1);
    chk("ready_wait", wr_ready, 0);
    cyc(700, 479);
    cyc(799, 479);
    cyc(0, 480);
    chk("ready_vb_edge", wr_ready, 0);
    exp_wr = 1'b1;
    cyc(1, 480);
    chk("ready_writing", wr_ready, 1);
    chk("first_addr", ram_addr, 0);
    chk("first_we", ram_we, 1);
    gh = 799;
    gv = 499;
    for (int i = 0; i < 5000 && n_acc < 1000; i++) step();
    chk("acc_1000", n_acc, 1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_pixel", pixel, 0);
    chk("mid_rst_done", done, 0);
    took = 1'b0;
    n_acc = 0;
    exp_wr = 1'b0;
    n_done = 0;
    fill_a5 = 1'b1;
    fill = 1'b1;
    cyc(700, 490);
    fill = 1'b0;
    cyc(700, 490);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(700, 490);
    chk("no_done_after_rst", n_done, 0);
    n_we = 0;
    cyc(0, 100);
    start = 1'b1;
    cyc(1, 100);
    start = 1'b0;
    cyc(0, 480);
    exp_wr = 1'b1;
    cyc(1, 480);
    chk("restart_addr", ram_addr, 0);
    chk("restart_we", ram_we, 1);
    gh = 799;
    gv = 499;
    for (int i = 0; i < 90000 && n_done == 0; i++) begin
      start = i == 2000;
      if (n_acc < 4000) step();
      else cyc(700, 490);
    end
    start = 1'b0;
    chk("done_seen", n_done, 1);
    chk("acc_total", n_acc, NPIX);
    chk("we_total", n_we, NPIX);
    chk("idle_after", busy, 0);
    for (int i = 0; i < 4; i++) cyc(700, 490);
    chk("done_single", n_done, 1);
    chk("no_extra_we", n_we, NPIX);
    wr_valid = 1'b0;
    for (int h = 0; h <= 645; h++) begin
      cyc(h, 479);
      if (h == 3) chk("disp_h3", pixel, 'hc0);
      if (h == 102) chk("disp_h102", pixel, 'hf2);
      if (h == 640) chk("disp_h640", pixel, 'hff);
      if (h == 641) chk("disp_h641", pixel, 'hff);
      if (h == 643) chk("disp_h643", pixel, 0);
    end
    for (int h = 0; h <= 8; h++) begin
      cyc(h, 0);
      if (h == 6) chk("disp_v0_h6", pixel, 'h02);
    end
    chk("bad_addr", bad_addr, 0);
    chk("bad_data", bad_data, 0);
    chk("we_in_slot", we_in_slot, 0);
    chk("ready_bad", ready_bad, 0);
    chk("done_bad", done_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
